// File: rtl/reg_writeback_pkg.sv
// Shared types and widths for the register-file writeback path.
//   REG_IDX_W  : register index width
//   REG_DATA_W : register data width
//   PEND_W     : width of the FIFO occupancy count (covers 0..16)
//   wb_entry   : {index, data} payload carried by both result sources
package reg_writeback_pkg;

  localparam int unsigned REG_IDX_W  = 5;
  localparam int unsigned REG_DATA_W = 16;
  localparam int unsigned PEND_W     = 5;

  typedef struct packed {
    logic [REG_IDX_W-1:0]  index;
    logic [REG_DATA_W-1:0] data;
  } wb_entry;

endpackage

// File: rtl/reg_writeback_if.sv
// Writeback bus bundle: ALU result, load result handshake, register-file write port.
//   master : result producers / register file side (drives alu_*, ld_valid/index/data)
//   slave  : the writeback block (drives alu_stall, ld_ready, w_*, pending)
interface reg_writeback_if;
  import reg_writeback_pkg::*;

  logic                  alu_valid;
  logic [REG_IDX_W-1:0]  alu_index;
  logic [REG_DATA_W-1:0] alu_data;
  logic                  alu_stall;
  logic                  ld_valid;
  logic                  ld_ready;
  logic [REG_IDX_W-1:0]  ld_index;
  logic [REG_DATA_W-1:0] ld_data;
  logic                  w_enable;
  logic [REG_IDX_W-1:0]  w_index;
  logic [REG_DATA_W-1:0] w_data;
  logic [PEND_W-1:0]     pending;

  modport master (
    output alu_valid, alu_index, alu_data, ld_valid, ld_index, ld_data,
    input  alu_stall, ld_ready, w_enable, w_index, w_data, pending
  );

  modport slave (
    input  alu_valid, alu_index, alu_data, ld_valid, ld_index, ld_data,
    output alu_stall, ld_ready, w_enable, w_index, w_data, pending
  );
endinterface

// File: rtl/reg_writeback_wb_fifo.sv
// wb_fifo: load-result FIFO, DEPTH entries (power of two, 2..16).
// Ports: clk, reset_n (sync, active-low), push/din, pop/head,
//        count (registered occupancy), full, empty (both from count).
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  wb_entry           din,
  input  logic              pop,
  output wb_entry           head,
  output logic [PEND_W-1:0] count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_entry            mem_q [DEPTH];
  wb_entry            mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PEND_W-1:0]  count_q, count_d;

  // Pointer, occupancy and storage update; pointers wrap naturally at DEPTH.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + PEND_W'(1);
      2'b01:   count_d = count_q - PEND_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; clearing pointers and count discards contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == PEND_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU results and queued load results onto one
// register-file write port, with a starvation guard for loads.
// Ports: clk, reset_n (sync, active-low), bus (reg_writeback_if.slave).
// Build option: define WB_R0_ZERO_EN to suppress writes to register 0.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  reg_writeback_if.slave  bus
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [PEND_W-1:0]     fifo_count;
  wb_entry               fifo_head, ld_entry, sel_entry;

  logic                  force_c, alu_stall_c, sel_alu, sel_valid, r0_drop;
  logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic                  w_enable_q, w_enable_d;
  logic [REG_IDX_W-1:0]  w_index_q, w_index_d;
  logic [REG_DATA_W-1:0] w_data_q, w_data_d;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (ld_entry),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Arbitration: ALU first unless loads have been starved for STARVE_MAX cycles.
  // A pushed load only becomes visible through the registered count, so it
  // cannot be selected in its own push cycle.
  always_comb begin
    ld_entry.index = bus.ld_index;
    ld_entry.data  = bus.ld_data;
    force_c        = (starve_cnt_q == STARVE_W'(STARVE_MAX));
    fifo_push      = bus.ld_valid && !fifo_full;
    sel_alu        = bus.alu_valid && !force_c;
    fifo_pop       = !sel_alu && !fifo_empty;
    sel_valid      = sel_alu || fifo_pop;
    alu_stall_c    = bus.alu_valid && force_c;
    sel_entry      = fifo_head;
    if (sel_alu) begin
      sel_entry.index = bus.alu_index;
      sel_entry.data  = bus.alu_data;
    end
  end

  // Starvation counter: counts ALU wins that left a waiting load behind.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || fifo_pop) begin
      starve_cnt_d = '0;
    end else if (sel_alu && !force_c) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end
  end

  // Write-port next state; an r0 entry is consumed but never strobed when enabled.
  always_comb begin
`ifdef WB_R0_ZERO_EN
    r0_drop = (sel_entry.index == '0);
`else
    r0_drop = 1'b0;
`endif
    w_enable_d = sel_valid && !r0_drop;
    w_index_d  = w_index_q;
    w_data_d   = w_data_q;
    if (sel_valid) begin
      w_index_d = sel_entry.index;
      w_data_d  = sel_entry.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      starve_cnt_q <= '0;
      w_enable_q   <= 1'b0;
      w_index_q    <= '0;
      w_data_q     <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      w_enable_q   <= w_enable_d;
      w_index_q    <= w_index_d;
      w_data_q     <= w_data_d;
    end
  end

  assign bus.alu_stall = alu_stall_c;
  assign bus.ld_ready  = !fifo_full;
  assign bus.w_enable  = w_enable_q;
  assign bus.w_index   = w_index_q;
  assign bus.w_data    = w_data_q;
  assign bus.pending   = fifo_count;

endmodule
